// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the instruction cache.
// Pure declarations: no latency, no flow control.
package icache_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned NUM_LINES  = 16;
    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned OFF_W      = $clog2(DATA_W / 8);
    localparam int unsigned WORD_W     = $clog2(LINE_WORDS);
    localparam int unsigned INDEX_W    = $clog2(NUM_LINES);
    localparam int unsigned TAG_W      = ADDR_W - INDEX_W - WORD_W - OFF_W;

    typedef enum logic [2:0] {
        IDLE,
        HIT_RSP,
        MISS_REQ,
        MISS_WAIT,
        MISS_RSP
    } state_t;

    // Field widths are passed in so a parameterised instance can reuse these helpers.
    function automatic logic [63:0] get_word(input logic [63:0] addr,
                                             input int unsigned off_w,
                                             input int unsigned word_w);
        return (addr >> off_w) & ((64'd1 << word_w) - 64'd1);
    endfunction

    function automatic logic [63:0] get_index(input logic [63:0] addr,
                                              input int unsigned off_w,
                                              input int unsigned word_w,
                                              input int unsigned index_w);
        return (addr >> (off_w + word_w)) & ((64'd1 << index_w) - 64'd1);
    endfunction

    function automatic logic [63:0] get_tag(input logic [63:0] addr,
                                            input int unsigned off_w,
                                            input int unsigned word_w,
                                            input int unsigned index_w);
        return addr >> (off_w + word_w + index_w);
    endfunction

endpackage

// File: rtl/icache_store.sv
// Valid/tag/data arrays of the direct-mapped cache: combinational read, 1-cycle writes.
// No flow control; flush clears every valid bit and overrides a same-cycle tag write.
module icache_store #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned LINES          = 16,
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned TAG_BITS       = 24
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [$clog2(LINES)-1:0]          rd_index,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] rd_word,
    output logic                              rd_valid,
    output logic [TAG_BITS-1:0]               rd_tag,
    output logic [DATA_WIDTH-1:0]             rd_data,
    input  logic                              wr_en,
    input  logic [$clog2(LINES)-1:0]          wr_index,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] wr_word,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    input  logic                              tag_wr_en,
    input  logic [TAG_BITS-1:0]               tag_wr_tag,
    input  logic                              tag_wr_valid,
    input  logic                              flush_all
);

    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [DATA_WIDTH-1:0] data_mem [LINES][WORDS_PER_LINE];

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index][rd_word];

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
        end else begin
            if (tag_wr_en) begin
                valid_q[wr_index] <= tag_wr_valid;
            end
            if (flush_all) begin
                valid_q <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tag_wr_en) begin
            tag_mem[wr_index] <= tag_wr_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_index][wr_word] <= wr_data;
        end
    end

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped read-only I-cache: hit answers 1 cycle after accept, miss refills a whole line.
// req_ready only in IDLE; one memory request outstanding; rsp is an unthrottled pulse.
module icache_responder
    import icache_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned LINES          = 16,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    output logic                     req_ready,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_instr,
    input  logic                     flush,
    output logic                     mem_req_valid,
    output logic [ADDRESS_WIDTH-1:0] mem_req_addr,
    input  logic                     mem_req_ready,
    input  logic                     mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]    mem_rsp_data
);

    localparam int unsigned OFS_BITS = $clog2(DATA_WIDTH / 8);
    localparam int unsigned WRD_BITS = $clog2(WORDS_PER_LINE);
    localparam int unsigned IDX_BITS = $clog2(LINES);
    localparam int unsigned TAG_BITS = ADDRESS_WIDTH - IDX_BITS - WRD_BITS - OFS_BITS;
    localparam logic [WRD_BITS-1:0] LAST_BEAT = WRD_BITS'(WORDS_PER_LINE - 1);
    localparam logic [ADDRESS_WIDTH-1:0] LINE_MASK =
        ADDRESS_WIDTH'((64'd1 << (OFS_BITS + WRD_BITS)) - 64'd1);

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] line_base_q;
    logic [TAG_BITS-1:0]      tag_q;
    logic [IDX_BITS-1:0]      index_q;
    logic [WRD_BITS-1:0]      req_word_q;
    logic [WRD_BITS-1:0]      beat;
    logic [WRD_BITS-1:0]      beat_nxt;
    logic                     flush_pending;

    logic [TAG_BITS-1:0]      lk_tag;
    logic [IDX_BITS-1:0]      lk_index;
    logic [WRD_BITS-1:0]      lk_word;
    logic                     rd_valid;
    logic [TAG_BITS-1:0]      rd_tag;
    logic [DATA_WIDTH-1:0]    rd_data;
    logic                     hit;
    logic                     refill_wr;
    logic                     refill_last;

    assign lk_tag   = TAG_BITS'(get_tag(64'(req_addr), OFS_BITS, WRD_BITS, IDX_BITS));
    assign lk_index = IDX_BITS'(get_index(64'(req_addr), OFS_BITS, WRD_BITS, IDX_BITS));
    assign lk_word  = WRD_BITS'(get_word(64'(req_addr), OFS_BITS, WRD_BITS));

    // Lookup sees the valid bits as they stand this cycle, so a same-cycle flush does not hide a hit.
    assign hit         = rd_valid && (rd_tag == lk_tag);
    assign req_ready   = (state == IDLE);
    assign beat_nxt    = beat + WRD_BITS'(1);
    assign refill_wr   = (state == MISS_WAIT) && mem_rsp_valid;
    assign refill_last = refill_wr && (beat == LAST_BEAT);

    icache_store #(
        .DATA_WIDTH     (DATA_WIDTH),
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_BITS       (TAG_BITS)
    ) u_store (
        .clk          (clk),
        .rst          (rst),
        .rd_index     (lk_index),
        .rd_word      (lk_word),
        .rd_valid     (rd_valid),
        .rd_tag       (rd_tag),
        .rd_data      (rd_data),
        .wr_en        (refill_wr),
        .wr_index     (index_q),
        .wr_word      (beat),
        .wr_data      (mem_rsp_data),
        .tag_wr_en    (refill_last),
        .tag_wr_tag   (tag_q),
        .tag_wr_valid (!flush_pending),
        .flush_all    (flush)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            rsp_valid     <= 1'b0;
            rsp_instr     <= '0;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            beat          <= '0;
            flush_pending <= 1'b0;
            line_base_q   <= '0;
            tag_q         <= '0;
            index_q       <= '0;
            req_word_q    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (flush && (state == MISS_REQ || state == MISS_WAIT)) begin
                flush_pending <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        line_base_q <= req_addr & ~LINE_MASK;
                        tag_q       <= lk_tag;
                        index_q     <= lk_index;
                        req_word_q  <= lk_word;
                        beat        <= '0;
                        if (hit) begin
                            rsp_valid <= 1'b1;
                            rsp_instr <= rd_data;
                            state     <= HIT_RSP;
                        end else begin
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= req_addr & ~LINE_MASK;
                            state         <= MISS_REQ;
                        end
                    end
                end
                HIT_RSP: begin
                    state <= IDLE;
                end
                MISS_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= MISS_WAIT;
                    end
                end
                MISS_WAIT: begin
                    if (mem_rsp_valid) begin
                        // Capture the requested word as it streams past instead of re-reading the line.
                        if (beat == req_word_q) begin
                            rsp_instr <= mem_rsp_data;
                        end
                        if (beat == LAST_BEAT) begin
                            rsp_valid <= 1'b1;
                            state     <= MISS_RSP;
                        end else begin
                            beat          <= beat_nxt;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= line_base_q | (ADDRESS_WIDTH'(beat_nxt) << OFS_BITS);
                            state         <= MISS_REQ;
                        end
                    end
                end
                MISS_RSP: begin
                    flush_pending <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
// Randomised scoreboard bench for icache_responder against a line-level cache model.
module tb_icache_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_instr;
    logic        flush;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    logic        flush_a = 1'b0, flush_b = 1'b0;
    logic        mem_auto = 1'b1;
    logic        auto_ready = 1'b0, auto_rsp = 1'b0;
    logic [31:0] auto_data = '0;
    logic        man_ready = 1'b0, man_rsp = 1'b0;
    logic [31:0] man_data = '0;
    bit          stall_arm = 1'b0, flush_arm = 1'b0;

    assign flush         = flush_a | flush_b;
    assign mem_req_ready = mem_auto ? auto_ready : man_ready;
    assign mem_rsp_valid = mem_auto ? auto_rsp : man_rsp;
    assign mem_rsp_data  = mem_auto ? auto_data : man_data;

    always #5 clk = ~clk;

    icache_responder dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_instr     (rsp_instr),
        .flush         (flush),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data)
    );

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;

    typedef struct {
        logic [31:0] data;
        bit          hit;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_mem_q[$];
    logic [31:0] img[logic [31:0]];
    bit          mv[16];
    logic [23:0] mt[16];

    initial forever begin
        @(posedge clk);
        cycle = cycle + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (img.exists(a)) return img[a];
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic model_flush();
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    endtask

    // Issue one fetch; the model decides hit/miss and predicts the refill addresses and data.
    task automatic do_req(input logic [31:0] addr, input bit flush_with, input bit flush_mid);
        int          idx;
        logic [23:0] tg;
        bit          hit;
        exp_t        e;
        int          n;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("req_ready_wait", 32'(req_ready), 32'd1);
        idx = int'(addr[7:4]);
        tg  = addr[31:8];
        hit = mv[idx] && (mt[idx] == tg);
        if (flush_with) model_flush();
        if (!hit) begin
            for (int b = 0; b < 4; b++) begin
                logic [1:0] bb;
                bb = b[1:0];
                exp_mem_q.push_back({addr[31:4], bb, 2'b00});
            end
            mv[idx] = 1'b1;
            mt[idx] = tg;
        end
        if (flush_mid) model_flush();
        e.data = mem_word({addr[31:2], 2'b00});
        e.hit  = hit;
        e.acc  = cycle;
        exp_q.push_back(e);
        req_valid = 1'b1;
        req_addr  = addr;
        flush_a   = flush_with;
        @(negedge clk);
        req_valid = 1'b0;
        flush_a   = 1'b0;
        req_addr  = $urandom;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("rsp_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            exp_mem_q.delete();
        end
    endtask

    // Response monitor: pops the scoreboard whenever the DUT pulses rsp_valid.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst === 1'b1 && rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_instr", rsp_instr, e.data);
                if (e.hit) check("hit_latency", 32'(cycle - e.acc), 32'd1);
            end
        end
    end

    // Backing memory: random ready delay and response latency, optional stall/flush injection.
    initial begin : mem_model
        int          mst;
        int          lat;
        int          stall_cnt;
        logic [31:0] cur;
        logic [31:0] stall_addr;
        mst = 0; lat = 0; stall_cnt = 0; cur = '0; stall_addr = '0;
        forever begin
            @(negedge clk);
            auto_ready = 1'b0;
            auto_rsp   = 1'b0;
            flush_b    = 1'b0;
            if (!mem_auto || rst !== 1'b1) begin
                mst = 0;
                stall_cnt = 0;
            end else begin
                case (mst)
                    0: if (mem_req_valid) begin
                        if (stall_arm && mem_req_addr[3:2] == 2'd2 && stall_cnt == 0) begin
                            stall_arm  = 1'b0;
                            stall_cnt  = 5;
                            stall_addr = (exp_mem_q.size() != 0) ? exp_mem_q[0] : 32'hFFFF_FFFF;
                        end
                        if (stall_cnt > 0) begin
                            check("stall_req_valid", 32'(mem_req_valid), 32'd1);
                            check("stall_req_addr", mem_req_addr, stall_addr);
                            check("stall_req_ready", 32'(req_ready), 32'd0);
                            stall_cnt--;
                        end else if ($urandom_range(0, 3) != 0) begin
                            auto_ready = 1'b1;
                            cur = mem_req_addr;
                            if (exp_mem_q.size() == 0) check("unexpected_mem_req", 32'(mem_req_valid), 32'd0);
                            else check("mem_req_addr", mem_req_addr, exp_mem_q.pop_front());
                            mst = 1;
                        end
                    end
                    1: begin
                        lat = int'($urandom_range(0, 2));
                        if (flush_arm && cur[3:2] == 2'd1) begin
                            flush_arm = 1'b0;
                            flush_b   = 1'b1;
                        end
                        mst = 2;
                    end
                    2: if (lat == 0) begin
                        auto_rsp  = 1'b1;
                        auto_data = mem_word(cur);
                        mst = 0;
                    end else begin
                        lat--;
                    end
                    default: mst = 0;
                endcase
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] a;
        rst = 1'b0;
        req_valid = 1'b0;
        req_addr = '0;
        model_flush();
        img[32'h100] = 32'hA0; img[32'h104] = 32'hA1;
        img[32'h108] = 32'hA2; img[32'h10C] = 32'hA3;
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_instr", rsp_instr, 32'd0);
        check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_mem_req_addr", mem_req_addr, 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        rst = 1'b1;
        @(negedge clk);

        do_req(32'h104, 1'b0, 1'b0);            // cold miss, 0xA1
        do_req(32'h10C, 1'b0, 1'b0);            // hit, 0xA3
        do_req(32'h204, 1'b0, 1'b0);            // conflict eviction
        do_req(32'h104, 1'b0, 1'b0);            // misses again
        stall_arm = 1'b1;
        do_req(32'h2C8, 1'b0, 1'b0);            // stall on beat 2
        check("stall_consumed", 32'(stall_arm), 32'd0);
        flush_arm = 1'b1;
        do_req(32'h148, 1'b0, 1'b1);            // flush during beat-1 wait
        check("flush_consumed", 32'(flush_arm), 32'd0);
        do_req(32'h148, 1'b0, 1'b0);            // must miss
        do_req(32'h148, 1'b1, 1'b0);            // flush with request: hit on pre-flush bits
        do_req(32'h148, 1'b0, 1'b0);            // now a miss

        // Reset in the middle of a refill, then a stray memory response.
        mem_auto = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h304;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!mem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t6_mem_req_valid", 32'(mem_req_valid), 32'd1);
        man_ready = 1'b1;
        @(negedge clk);
        man_ready = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t6_rsp_instr", rsp_instr, 32'd0);
        check("t6_mem_req_valid_rst", 32'(mem_req_valid), 32'd0);
        check("t6_mem_req_addr", mem_req_addr, 32'd0);
        rst = 1'b1;
        man_rsp = 1'b1;
        man_data = 32'hDEAD_BEEF;
        @(negedge clk);
        man_rsp = 1'b0;
        check("t6_late_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t6_late_mem_req", 32'(mem_req_valid), 32'd0);
        @(negedge clk);
        check("t6_idle_ready", 32'(req_ready), 32'd1);
        check("t6_idle_rsp", 32'(rsp_valid), 32'd0);
        model_flush();
        mem_auto = 1'b1;
        do_req(32'h104, 1'b0, 1'b0);            // cold after reset

        for (int i = 0; i < 80; i++) begin
            int r;
            a = (32'($urandom_range(0, 5)) << 8) | (32'($urandom_range(0, 63)) << 2)
                | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a[31:24] = 8'hFF;
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                flush_a = 1'b1;
                @(negedge clk);
                flush_a = 1'b0;
                model_flush();
            end
            do_req(a, r == 1, 1'b0);
        end

        repeat (5) @(negedge clk);
        check("leftover_mem_reqs", 32'(exp_mem_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Instruction-side responder for the fetch stage. Accepts a PC fetch request and returns the 32-bit instruction word.
- Direct-mapped, read-only instruction cache. Misses are refilled from a backing instruction memory through a request/response handshake, one word per beat.
- Sits between the fetch stage's PC output and the instruction memory. Its response feeds decode.

Parameters:
ADDRESS_WIDTH, 32, byte address width of requests and memory addresses
DATA_WIDTH, 32, instruction word width
LINES, 16, number of cache lines (power of two)
WORDS_PER_LINE, 4, words per line (power of two, >=2)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset; synchronous, active-low (0 = reset)
req_valid  in  1  fetch request present
req_addr  in  ADDRESS_WIDTH  fetch PC (byte address)
req_ready  out  1  responder can accept a request; high only in IDLE
rsp_valid  out  1  single-cycle pulse; rsp_instr valid
rsp_instr  out  DATA_WIDTH  instruction word for the accepted request
flush  in  1  invalidate all lines
mem_req_valid  out  1  backing-memory word read request
mem_req_addr  out  ADDRESS_WIDTH  word-aligned byte address of the requested word
mem_req_ready  in  1  memory accepts the request
mem_rsp_valid  in  1  memory returns a word
mem_rsp_data  in  DATA_WIDTH  returned word

Behaviour:
- Address split, LINES=16 and WORDS_PER_LINE=4:
  - [1:0] byte offset, ignored.
  - [3:2] word index.
  - [7:4] line index.
  - [31:8] tag.
  - Widths are derived with $clog2.
- Storage per line: valid bit, tag, WORDS_PER_LINE data words.
- Reset: all valid bits 0; state IDLE; rsp_valid=0, rsp_instr=0, mem_req_valid=0, mem_req_addr=0, beat counter 0, flush_pending 0.
- FSM states: IDLE, HIT_RSP, MISS_REQ, MISS_WAIT, MISS_RSP.
- IDLE:
  - req_ready=1. Accept when req_valid=1 and register the address.
  - Tag compare is done on the incoming address in the same cycle.
  - Hit → HIT_RSP; miss → MISS_REQ with beat=0.
- HIT_RSP: rsp_valid=1 with the cached word, then → IDLE. Hit latency is exactly 1 cycle after acceptance.
- MISS_REQ:
  - mem_req_valid=1, mem_req_addr = {tag, index, beat, 2'b00}.
  - mem_req_valid and mem_req_addr are held stable until mem_req_ready=1, then → MISS_WAIT.
- MISS_WAIT:
  - On mem_rsp_valid, write mem_rsp_data into line word[beat].
  - If beat != WORDS_PER_LINE-1: beat+1, → MISS_REQ.
  - Else: write the tag; set valid unless flush_pending; → MISS_RSP.
- MISS_RSP: rsp_valid=1 with the requested word from the refilled line, then → IDLE. Clear flush_pending.
- Refill order is always beat 0..WORDS_PER_LINE-1 (no critical-word-first).
- mem_rsp_valid outside MISS_WAIT is ignored.
- Only one outstanding memory request at a time.
- rsp has no backpressure; the fetch stage must consume the pulse.
- flush:
  - Any cycle: all valid bits clear next edge.
  - If asserted in MISS_REQ or MISS_WAIT, set flush_pending. The refill completes and responds but leaves the line invalid.
  - flush in IDLE together with req_valid: the request is accepted and looked up against the pre-flush valid bits.
- Eviction: a miss overwrites the indexed line unconditionally (read-only cache, no writeback).
- Reset mid-refill: state → IDLE, mem_req_valid drops the same edge. Any in-flight memory response afterwards is ignored.

Decomposition:
- Shared package icache_pkg:
  - state enum (IDLE, HIT_RSP, MISS_REQ, MISS_WAIT, MISS_RSP).
  - Localparams for offset, word, index and tag widths.
  - Functions to extract tag, index and word from an address.
- One natural sub-module: icache_store. Holds the valid, tag and data arrays. Provides a combinational read port, a per-word write, a tag/valid write, and a flush-all.
- The FSM stays in icache_responder.

Test Plan:
1. Cold miss:
   - Stimulus: after reset, request addr 0x0000_0104. Memory returns 0xA0, 0xA1, 0xA2, 0xA3 for 0x100..0x10C with 1-cycle ready.
   - Response: four mem_req_addr values, 0x100, 0x104, 0x108, 0x10C, in order; rsp_instr=0xA1 in MISS_RSP.
2. Hit:
   - Stimulus: then request 0x10C.
   - Response: no mem_req_valid; rsp_valid exactly 1 cycle after acceptance with 0xA3.
3. Conflict eviction:
   - Stimulus: request 0x0000_0204, same index, different tag.
   - Response: refill from 0x200. A subsequent request to 0x104 misses again.
4. Memory stall:
   - Stimulus: mem_req_ready held 0 for 5 cycles on beat 2.
   - Response: mem_req_valid and mem_req_addr stay stable; req_ready stays 0 throughout.
5. Flush during refill:
   - Stimulus: assert flush in MISS_WAIT of beat 1.
   - Response: the response still delivers the correct word; the next request to the same address misses.
6. Reset mid-refill:
   - Stimulus: rst=0 in MISS_WAIT, then a late mem_rsp_valid.
   - Response: all outputs are at reset values; the late response is ignored; the next request to 0x104 misses.
